// File: rtl/irq_ctrl.sv
// Prioritising interrupt controller: latches edge/level requests, raises one
// request to the CPU, and tracks the acknowledge / end-of-interrupt handshake.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   EX_irq     raw interrupt lines (synchronous to clk)
//   cfg_we     enable-mask write strobe
//   cfg_wdata  new enable mask
//   INT_irq    registered request to the CPU control FSM
//   INTA_irq   CPU acknowledge pulse
//   irq_eoi    CPU end-of-interrupt pulse
//   irq_id     id of the source being serviced
//   in_service high while a handler runs
//   pending    raw pending status, before masking
module irq_ctrl #(
    parameter int              N_SRC     = 4,
    parameter int              ID_W      = 2,
    parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] EX_irq,
    input  logic             cfg_we,
    input  logic [N_SRC-1:0] cfg_wdata,
    output logic             INT_irq,
    input  logic             INTA_irq,
    input  logic             irq_eoi,
    output logic [ID_W-1:0]  irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] pend_nxt;
    logic [ID_W-1:0]  win;
    logic             take;

    assign active   = pending & enable;
    assign edge_set = EX_irq & ~prev & EDGE_MASK;

    // Lowest index wins: scan downwards so the last hit is the lowest bit.
    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|active) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A withdrawn or masked request cancels regardless of INTA.
                if (!(|active)) begin
                    state_nxt = IDLE;
                end else if (INTA_irq) begin
                    state_nxt = SERV;
                    take      = 1'b1;
                end
            end
            SERV: begin
                if (irq_eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Only edge sources are cleared by acknowledge; a new edge in the same
    // cycle re-sets the bit because set is OR-ed in after the clear.
    always_comb begin
        ack_clr = '0;
        if (take) begin
            ack_clr = (N_SRC'(1) << win) & EDGE_MASK;
        end
        pend_nxt = (EDGE_MASK & ((pending & ~ack_clr) | edge_set))
                 | (~EDGE_MASK & EX_irq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= EX_irq;
            pending    <= '0;
            enable     <= '1;
            irq_id     <= '0;
            INT_irq    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= EX_irq;
            pending    <= pend_nxt;
            INT_irq    <= (state_nxt == REQ);
            in_service <= (state_nxt == SERV);
            if (cfg_we) begin
                enable <= cfg_wdata;
            end
            if (take) begin
                irq_id <= win;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl; source 0 is level, sources 1..3 edge.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] EX_irq;
    logic       cfg_we;
    logic [3:0] cfg_wdata;
    logic       INT_irq;
    logic       INTA_irq;
    logic       irq_eoi;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] ex;
        logic       we;
        logic [3:0] wd;
        logic       inta;
        logic       eoi;
        logic       e_int;
        logic       e_ins;
        logic [1:0] e_id;
        logic [3:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    irq_ctrl #(
        .N_SRC    (4),
        .ID_W     (2),
        .EDGE_MASK(4'b1110)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .EX_irq    (EX_irq),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .INT_irq   (INT_irq),
        .INTA_irq  (INTA_irq),
        .irq_eoi   (irq_eoi),
        .irq_id    (irq_id),
        .in_service(in_service),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_int,
                           input logic e_ins, input logic [1:0] e_id,
                           input logic [3:0] e_pend);
        chk({tag, " INT_irq"}, {3'b0, INT_irq}, {3'b0, e_int});
        chk({tag, " in_service"}, {3'b0, in_service}, {3'b0, e_ins});
        chk({tag, " irq_id"}, {2'b0, irq_id}, {2'b0, e_id});
        chk({tag, " pending"}, pending, e_pend);
    endtask

    task automatic add(input logic [3:0] ex, input logic we,
                       input logic [3:0] wd, input logic inta,
                       input logic eoi, input logic e_int,
                       input logic e_ins, input logic [1:0] e_id,
                       input logic [3:0] e_pend);
        vec_t v;
        v.ex = ex; v.we = we; v.wd = wd; v.inta = inta; v.eoi = eoi;
        v.e_int = e_int; v.e_ins = e_ins; v.e_id = e_id; v.e_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic idle_in();
        EX_irq = 4'b0; cfg_we = 1'b0; cfg_wdata = 4'b0;
        INTA_irq = 1'b0; irq_eoi = 1'b0;
    endtask

    initial begin
        // ex, we, wd, inta, eoi | int, ins, id, pend
        // single edge on source 2
        add(4'b0100, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 1, 2'd2, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 1, 2'd2, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd2, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd2, 4'b0000);
        // priority 3 and 1
        add(4'b1010, 0, 4'h0, 0, 0, 0, 0, 2'd2, 4'b1010);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd2, 4'b1010);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 1, 2'd1, 4'b1000);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd1, 4'b1000);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd1, 4'b1000);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 1, 2'd3, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd3, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd3, 4'b0000);
        // stray INTA / EOI while idle
        add(4'b0000, 0, 4'h0, 1, 1, 0, 0, 2'd3, 4'b0000);
        // level source 0 withdrawn before INTA
        add(4'b0001, 0, 4'h0, 0, 0, 0, 0, 2'd3, 4'b0001);
        add(4'b0001, 0, 4'h0, 0, 0, 1, 0, 2'd3, 4'b0001);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd3, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd3, 4'b0000);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 2'd3, 4'b0000);
        // level source acknowledged: pending follows the line
        add(4'b0001, 0, 4'h0, 0, 0, 0, 0, 2'd3, 4'b0001);
        add(4'b0001, 0, 4'h0, 0, 0, 1, 0, 2'd3, 4'b0001);
        add(4'b0001, 0, 4'h0, 1, 0, 0, 1, 2'd0, 4'b0001);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd0, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'b0000);
        // masking source 2
        add(4'b0000, 1, 4'hB, 0, 0, 0, 0, 2'd0, 4'b0000);
        add(4'b0100, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 1, 4'hF, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'b0100);
        // mask during REQ cancels even with INTA
        add(4'b0000, 1, 4'hB, 0, 0, 1, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 1, 4'hF, 0, 0, 0, 0, 2'd0, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd0, 4'b0100);
        // ack with a fresh edge on the same source: set wins
        add(4'b0100, 0, 4'h0, 1, 0, 0, 1, 2'd2, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd2, 4'b0100);
        add(4'b0000, 0, 4'h0, 0, 0, 1, 0, 2'd2, 4'b0100);
        add(4'b0000, 0, 4'h0, 1, 0, 0, 1, 2'd2, 4'b0000);
        add(4'b0000, 0, 4'h0, 0, 1, 0, 0, 2'd2, 4'b0000);

        // reset with line 1 held high through release
        idle_in();
        rst = 1'b1;
        EX_irq = 4'b0010;
        step();
        step();
        chk_all("reset", 0, 0, 2'd0, 4'b0000);
        rst = 1'b0;
        step();
        chk_all("held-high release", 0, 0, 2'd0, 4'b0000);
        step();
        chk_all("held-high +1", 0, 0, 2'd0, 4'b0000);
        EX_irq = 4'b0000;
        step();
        chk_all("line drop", 0, 0, 2'd0, 4'b0000);

        foreach (vecs[i]) begin
            EX_irq    = vecs[i].ex;
            cfg_we    = vecs[i].we;
            cfg_wdata = vecs[i].wd;
            INTA_irq  = vecs[i].inta;
            irq_eoi   = vecs[i].eoi;
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_int, vecs[i].e_ins,
                    vecs[i].e_id, vecs[i].e_pend);
        end

        // reset during service; mask also returns to all ones
        idle_in();
        cfg_we = 1'b1;
        cfg_wdata = 4'b1011;
        step();
        idle_in();
        EX_irq = 4'b1000;
        step();
        chk_all("pre-rst pend", 0, 0, 2'd2, 4'b1000);
        EX_irq = 4'b0000;
        step();
        chk_all("pre-rst req", 1, 0, 2'd2, 4'b1000);
        INTA_irq = 1'b1;
        step();
        chk_all("pre-rst serv", 0, 1, 2'd3, 4'b0000);
        INTA_irq = 1'b0;
        rst = 1'b1;
        step();
        chk_all("rst in serv", 0, 0, 2'd0, 4'b0000);
        rst = 1'b0;
        EX_irq = 4'b0100;
        step();
        chk_all("post-rst pend", 0, 0, 2'd0, 4'b0100);
        EX_irq = 4'b0000;
        step();
        chk_all("post-rst mask", 1, 0, 2'd0, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
